// File: rtl/eq_pkg.sv
// Shared constants, the I2C slave state type and the gain mapping helper for the
// equalizer control plane.
package eq_pkg;

    localparam int unsigned GAIN_FRAC = 9;
    localparam int unsigned GAIN_W    = 13;
    localparam int unsigned AUDIO_W   = 24;
    localparam int unsigned NUM_BANDS = 10;

    localparam logic [7:0] REG_GAIN_FIRST  = 8'h01;
    localparam logic [7:0] REG_GAIN_LAST   = 8'h0A;
    localparam logic [7:0] GAIN_RESET_CODE = 8'h10;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAckA,
        StReg,
        StAckR,
        StData,
        StAckD
    } i2c_state_e;

    // Code 16 is unity: the 8-bit code sits above GAIN_W-8 zero fraction bits.
    function automatic logic [GAIN_W-1:0] code_to_gain(input logic [7:0] code);
        return {code, 5'b0};
    endfunction

endpackage

// File: rtl/eq_top_module_i2c_slave_wr.sv
// Write-only I2C slave: input synchronizers, START/STOP detection, byte FSM, ACK drive
// and the register write strobe.
module i2c_slave_wr
    import eq_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h6A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_data,
    output logic       o_reg_we
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;

    i2c_state_e r_state;
    i2c_state_e w_state_d;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_data;
    logic       r_reg_we;

    logic w_shift_en;
    logic w_cnt_clr;
    logic w_load_ptr;
    logic w_write;
    logic w_ack_drive;

    // Bus idles high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], io_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_shift_en = 1'b0;
        w_cnt_clr  = 1'b0;
        w_load_ptr = 1'b0;
        w_write    = 1'b0;
        if (w_start) begin
            w_state_d = StAddr;
            w_cnt_clr = 1'b1;
        end else if (w_stop) begin
            w_state_d = StIdle;
            w_cnt_clr = 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_d = StIdle;
                end
                StAddr, StReg, StData: begin
                    // Byte completes on the scl fall that follows its 8th rising edge.
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shift_en = 1'b1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_cnt_clr = 1'b1;
                        if (r_state == StAddr) begin
                            w_state_d = (r_shift == {SLAVE_ADDR, 1'b0}) ? StAckA : StIdle;
                        end else if (r_state == StReg) begin
                            w_state_d  = StAckR;
                            w_load_ptr = 1'b1;
                        end else begin
                            w_state_d = StAckD;
                            w_write   = 1'b1;
                        end
                    end
                end
                StAckA: begin
                    if (w_scl_fall) begin
                        w_state_d = StReg;
                        w_cnt_clr = 1'b1;
                    end
                end
                StAckR, StAckD: begin
                    if (w_scl_fall) begin
                        w_state_d = StData;
                        w_cnt_clr = 1'b1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_ptr      <= 8'h00;
            r_reg_addr <= 8'h00;
            r_reg_data <= 8'h00;
            r_reg_we   <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            if (w_cnt_clr) begin
                r_bit_cnt <= 4'd0;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[6:0], w_sda};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_load_ptr) begin
                r_ptr <= r_shift;
            end
            if (w_write) begin
                r_reg_addr <= r_ptr;
                r_reg_data <= r_shift;
                r_reg_we   <= 1'b1;
                r_ptr      <= r_ptr + 8'd1;
            end
        end
    end

    assign w_ack_drive = (r_state == StAckA) || (r_state == StAckR) || (r_state == StAckD);
    assign io_sda      = w_ack_drive ? 1'b0 : 1'bz;

    assign o_reg_addr = r_reg_addr;
    assign o_reg_data = r_reg_data;
    assign o_reg_we   = r_reg_we;

endmodule

// File: rtl/eq_top_module.sv
// Equalizer control-plane top: band-gain code registers written over I2C, Q4.9 gain
// export and the saturating broadband gain stage on the audio path.
module eq_top_module
    import eq_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h6A
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scl,
    inout  wire                sda,
    output logic [GAIN_W-1:0]  gain_1,
    output logic [GAIN_W-1:0]  gain_2,
    output logic [GAIN_W-1:0]  gain_3,
    output logic [GAIN_W-1:0]  gain_4,
    output logic [GAIN_W-1:0]  gain_5,
    output logic [GAIN_W-1:0]  gain_6,
    output logic [GAIN_W-1:0]  gain_7,
    output logic [GAIN_W-1:0]  gain_8,
    output logic [GAIN_W-1:0]  gain_9,
    output logic [GAIN_W-1:0]  gain_10,
    output logic [7:0]         reg_addr,
    output logic [7:0]         reg_data,
    output logic               reg_we,
    input  logic [AUDIO_W-1:0] audio_in,
    input  logic               audio_valid,
    output logic [AUDIO_W-1:0] audio_out
);

    localparam int unsigned PROD_W = AUDIO_W + GAIN_W + 1;
    localparam logic signed [PROD_W-1:0] SAT_MAX = 38'sd8388607;
    localparam logic signed [PROD_W-1:0] SAT_MIN = -38'sd8388608;

    logic [7:0]  r_code [NUM_BANDS];
    logic [7:0]  w_off;
    logic        w_wr_gain;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_scaled;
    logic [AUDIO_W-1:0]       w_sat;
    logic [AUDIO_W-1:0]       r_audio;

    i2c_slave_wr #(
        .SLAVE_ADDR (SLAVE_ADDR)
    ) u_i2c (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl),
        .io_sda     (sda),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .o_reg_we   (reg_we)
    );

    assign w_off     = reg_addr - REG_GAIN_FIRST;
    assign w_wr_gain = reg_we && (reg_addr >= REG_GAIN_FIRST) && (reg_addr <= REG_GAIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_code[i] <= GAIN_RESET_CODE;
            end
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (w_wr_gain && w_off == 8'(i)) begin
                    r_code[i] <= reg_data;
                end
            end
        end
    end

    assign gain_1  = code_to_gain(r_code[0]);
    assign gain_2  = code_to_gain(r_code[1]);
    assign gain_3  = code_to_gain(r_code[2]);
    assign gain_4  = code_to_gain(r_code[3]);
    assign gain_5  = code_to_gain(r_code[4]);
    assign gain_6  = code_to_gain(r_code[5]);
    assign gain_7  = code_to_gain(r_code[6]);
    assign gain_8  = code_to_gain(r_code[7]);
    assign gain_9  = code_to_gain(r_code[8]);
    assign gain_10 = code_to_gain(r_code[9]);

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign w_prod   = $signed(audio_in) * $signed({1'b0, gain_1});
    assign w_scaled = w_prod >>> GAIN_FRAC;

    always_comb begin
        w_sat = w_scaled[AUDIO_W-1:0];
        if (w_scaled > SAT_MAX) begin
            w_sat = 24'h7FFFFF;
        end else if (w_scaled < SAT_MIN) begin
            w_sat = 24'h800000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_audio <= '0;
        end else if (audio_valid) begin
            r_audio <= w_sat;
        end
    end

    assign audio_out = r_audio;

endmodule

// File: tb/tb_eq_top_module.sv
// Self-checking bench for eq_top_module: I2C master driver, register/gain model and an
// arithmetic audio reference.
module tb_eq_top_module;

    logic        clk;
    logic        rst_n;
    logic        scl;
    logic        m_sda;
    wire         sda;
    wire  [12:0] gain [1:10];
    logic [7:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        reg_we;
    logic [23:0] audio_in;
    logic        audio_valid;
    logic [23:0] audio_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_code [1:10];
    logic [7:0]  exp_addr_q [$];
    logic [7:0]  exp_data_q [$];
    logic [7:0]  got_addr_q [$];
    logic [7:0]  got_data_q [$];
    logic [7:0]  tx_q [$];
    logic [23:0] exp_audio;
    logic        ack;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;

    eq_top_module dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl         (scl),
        .sda         (sda),
        .gain_1      (gain[1]),
        .gain_2      (gain[2]),
        .gain_3      (gain[3]),
        .gain_4      (gain[4]),
        .gain_5      (gain[5]),
        .gain_6      (gain[6]),
        .gain_7      (gain[7]),
        .gain_8      (gain[8]),
        .gain_9      (gain[9]),
        .gain_10     (gain[10]),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .reg_we      (reg_we),
        .audio_in    (audio_in),
        .audio_valid (audio_valid),
        .audio_out   (audio_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (reg_we) begin
            got_addr_q.push_back(reg_addr);
            got_data_q.push_back(reg_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_audio(input logic [23:0] s, input logic [7:0] code);
        longint x;
        longint p;
        longint q;
        x = longint'($signed(s));
        p = x * (longint'(code) * 32);
        q = (p >= 0) ? p / 512 : -((-p + 511) / 512);
        if (q > 8388607) q = 8388607;
        if (q < -8388608) q = -8388608;
        return 24'(q);
    endfunction

    task automatic i2c_start();
        #50 m_sda = 1'b1;
        #50 scl = 1'b1;
        #100 m_sda = 1'b0;
        #100 scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #50 m_sda = 1'b0;
        #50 scl = 1'b1;
        #100 m_sda = 1'b1;
        #200;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            #50 m_sda = d[7-i];
            #50 scl = 1'b1;
            #100 scl = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] d, output logic got_ack);
        send_bits(d, 8);
        #50 m_sda = 1'b1;
        #50 scl = 1'b1;
        #50 got_ack = (sda === 1'b0);
        #50 scl = 1'b0;
    endtask

    task automatic check_we();
        chk("we_count", 32'(got_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size(); i++) begin
            if (i < got_addr_q.size()) begin
                chk("we_addr", 32'(got_addr_q[i]), 32'(exp_addr_q[i]));
                chk("we_data", 32'(got_data_q[i]), 32'(exp_data_q[i]));
            end
        end
        got_addr_q.delete();
        got_data_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic check_gains();
        for (int b = 1; b <= 10; b++) begin
            chk($sformatf("gain_%0d", b), 32'(gain[b]), 32'(ref_code[b]) * 32);
        end
    endtask

    // Full write transaction: address, pointer, then every byte queued in tx_q.
    task automatic write_tx(input logic [7:0] ptr);
        logic [7:0] p;
        i2c_start();
        write_byte(8'hD4, ack);
        chk("ack_addr", 32'(ack), 32'd1);
        write_byte(ptr, ack);
        chk("ack_ptr", 32'(ack), 32'd1);
        p = ptr;
        foreach (tx_q[k]) begin
            write_byte(tx_q[k], ack);
            chk("ack_data", 32'(ack), 32'd1);
            exp_addr_q.push_back(p);
            exp_data_q.push_back(tx_q[k]);
            if (p >= 8'h01 && p <= 8'h0A) ref_code[p] = tx_q[k];
            p = p + 8'd1;
        end
        i2c_stop();
        repeat (5) @(negedge clk);
        check_we();
        check_gains();
    endtask

    // Called at a negedge; inputs are captured on the following posedge.
    task automatic audio_step(input logic [23:0] s, input logic v);
        audio_in    = s;
        audio_valid = v;
        if (v) exp_audio = ref_audio(s, ref_code[1]);
        @(negedge clk);
        chk("audio_out", 32'(audio_out), 32'(exp_audio));
    endtask

    initial begin
        rst_n       = 1'b0;
        scl         = 1'b1;
        m_sda       = 1'b1;
        audio_in    = '0;
        audio_valid = 1'b0;
        exp_audio   = '0;
        for (int b = 1; b <= 10; b++) ref_code[b] = 8'h10;

        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_gains();
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_audio", 32'(audio_out), 32'd0);

        // Burst of ten 0x11 codes starting at register 1.
        tx_q.delete();
        for (int k = 0; k < 10; k++) tx_q.push_back(8'h11);
        write_tx(8'h01);

        // Foreign address is NACKed and writes nothing.
        i2c_start();
        write_byte(8'hD6, ack);
        chk("nack_addr", 32'(ack), 32'd0);
        write_byte(8'h02, ack);
        chk("nack_follow", 32'(ack), 32'd0);
        i2c_stop();
        repeat (5) @(negedge clk);
        check_we();
        check_gains();

        // Read request is NACKed too.
        i2c_start();
        write_byte(8'hD5, ack);
        chk("nack_read", 32'(ack), 32'd0);
        i2c_stop();

        @(negedge clk);
        for (int k = 0; k < 5; k++) audio_step(24'h100000, 1'b1);
        chk("audio_unity_544", 32'(audio_out), 32'h110000);
        audio_step(24'h0ABCDE, 1'b0);
        audio_step(24'hF00000, 1'b1);

        // Saturation with the maximum master gain.
        tx_q.delete();
        tx_q.push_back(8'hFF);
        write_tx(8'h01);
        @(negedge clk);
        audio_step(24'h7FFFFF, 1'b1);
        chk("sat_pos", 32'(audio_out), 32'h7FFFFF);
        audio_step(24'h800000, 1'b1);
        chk("sat_neg", 32'(audio_out), 32'h800000);

        // Two-byte write at register 3, then an out-of-range register.
        tx_q.delete();
        tx_q.push_back(8'h0E);
        tx_q.push_back(8'h0F);
        write_tx(8'h03);
        chk("gain_3_448", 32'(gain[3]), 32'd448);
        tx_q.delete();
        tx_q.push_back(8'h55);
        write_tx(8'h0E);
        tx_q.delete();
        tx_q.push_back(8'h21);
        tx_q.push_back(8'h22);
        write_tx(8'hFF);

        // STOP in the middle of a data byte.
        i2c_start();
        write_byte(8'hD4, ack);
        write_byte(8'h05, ack);
        send_bits(8'hA5, 3);
        i2c_stop();
        repeat (5) @(negedge clk);
        check_we();
        check_gains();

        // Repeated START mid-byte restarts at the address phase.
        i2c_start();
        write_byte(8'hD4, ack);
        write_byte(8'h07, ack);
        send_bits(8'h3C, 2);
        tx_q.delete();
        tx_q.push_back(8'h20);
        write_tx(8'h07);
        chk("gain_7_rs", 32'(gain[7]), 32'd1024);

        // Randomized bursts interleaved with random audio.
        for (int t = 0; t < 6; t++) begin
            logic [7:0] ptr;
            int         n;
            ptr = (t == 5) ? 8'hFE : 8'($urandom_range(0, 12));
            n   = $urandom_range(1, 4);
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            write_tx(ptr);
            @(negedge clk);
            for (int k = 0; k < 4; k++) audio_step(24'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset mid-transfer restores defaults and releases sda.
        i2c_start();
        write_byte(8'hD4, ack);
        write_byte(8'h02, ack);
        send_bits(8'hFF, 8);
        #80 rst_n = 1'b0;
        for (int b = 1; b <= 10; b++) ref_code[b] = 8'h10;
        exp_audio = '0;
        #40;
        chk("rst_mid_sda", 32'(sda), 32'd1);
        scl   = 1'b1;
        m_sda = 1'b1;
        #100 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        got_addr_q.delete();
        got_data_q.delete();
        check_gains();
        chk("rst_mid_audio", 32'(audio_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
